seq_scan_controller: RTL and testbench
======================================

# seq_scan_controller

Word-level controller that time-shares the team's serial sequence recognizer (input `x`, Mealy output `z`) among parallel data words. The controller accepts a WIDTH-bit word over a valid/ready handshake and clears the recognizer. It then shifts the word into the recognizer MSB-first, one bit per clock, and counts `z` pulses. When the scan finishes, it returns a match count and the first-match position over a second valid/ready handshake. The controller sits between a word-oriented producer/consumer and the bit-serial recognizer instance.

## Interface
- WIDTH, 8: bits per scanned word (≥2).
- CNT_W, 4: match counter width; counter saturates.
- POS_W, $clog2(WIDTH): width of first-match index.

- clock  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- in_valid  in  1  word available.
- in_ready  out  1  controller can accept a word.
- in_data  in  WIDTH  word to scan; bit WIDTH-1 is shifted first.
- rec_x  out  1  serial bit to recognizer `x`.
- rec_clear  out  1  holds recognizer in its initial state (wired to recognizer reset).
- rec_z  in  1  recognizer Mealy output, combinational in current `rec_x`.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_count  out  CNT_W  number of shift cycles with rec_z=1, saturating at 2^CNT_W-1.
- out_hit  out  1  at least one match in the word.
- out_first  out  POS_W  shift index (0 = first bit) of the first match; 0 when out_hit=0.

## Operation
- FSM states: IDLE, SHIFT, DONE; state, shift register, bit index, count, and first-match registers are all flopped.
- IDLE:
  - Outputs: in_ready=1, rec_clear=1, rec_x=0.
  - On in_valid&in_ready: load in_data into shift reg; clear count, hit, first, and bit index; go to SHIFT.
- SHIFT:
  - Outputs: in_ready=0, rec_clear=0, rec_x=shift_reg[WIDTH-1].
  - Each cycle, rec_z is sampled in that same cycle and attributed to the current bit index.
  - If rec_z=1: count increments (held at max if already saturated). If hit=0, set hit=1 and first=index.
  - Each cycle, shift reg shifts left by one and index increments.
  - After index WIDTH-1 is processed, go to DONE.
- DONE:
  - Outputs: out_valid=1, rec_clear=1, rec_x=0, in_ready=0.
  - out_count, out_hit, and out_first are stable while out_valid=1.
  - On out_ready, go to IDLE.
- rec_z is ignored in IDLE and DONE.
- Every word is scanned from the recognizer initial state: no match spans two words.
- in_data is ignored outside the accepting handshake. in_valid may drop without penalty while in_ready=0.

## Timing
- While reset=1 and in the cycle after reset release: state=IDLE, out_valid=0, out_count=0, out_hit=0, out_first=0, rec_x=0, rec_clear=1.
- in_ready is forced 0 while reset=1 and is 1 in the first cycle after release.
- Handshake at edge t moves the FSM to SHIFT.
  - Bit i is driven on rec_x during cycle t+1+i, for i=0..WIDTH-1.
  - out_valid rises in cycle t+WIDTH+1.
- Result handshake at edge u: IDLE (in_ready=1) in cycle u+1. Minimum period is WIDTH+2 cycles per word.
- DONE with out_ready already high lasts exactly one cycle.
- out_ready held low stalls DONE indefinitely; the result and rec_clear=1 are held.
- rec_clear deasserts in the first SHIFT cycle (recognizer state is reset during the accept cycle) and reasserts in the cycle after the last bit.
- Reset asserted mid-SHIFT or mid-DONE: the next state is IDLE and all outputs return to their reset values. A partial result is discarded, not presented.
- Count saturation with CNT_W=1 and WIDTH=8: count stops at 1, and hit/first are still correct.

## Test plan
- Reset, then in_data=8'b1010_0110 with bench rec_z tied 0 -> rec_x sequence 1,0,1,0,0,1,1,0 in cycles t+1..t+8; out_valid at t+9; out_count=0, out_hit=0, out_first=0.
- Bench drives rec_z=1 on shift indices 2 and 5 -> out_count=2, out_hit=1, out_first=2.
- rec_z=1 on all 8 indices with CNT_W=3 -> out_count=7 (saturated), out_first=0.
- out_ready held low 5 cycles in DONE -> out_valid and result stable, in_ready=0, rec_clear=1; release -> in_ready=1 next cycle; a back-to-back second word starts its shift with rec_clear pulse observed.
- reset asserted at shift index 4 -> next cycle IDLE, out_valid=0, count=0, rec_clear=1; a new word then scans with a clean count.
- in_valid pulsed during SHIFT and DONE -> ignored; no extra scan, and rec_x follows only the first word.

Source files
------------

// File: rtl/seq_scan_controller.sv
// Time-shares a bit-serial sequence recognizer across WIDTH-bit words:
// accepts a word, shifts it out MSB-first, counts z pulses, returns the result.
module seq_scan_controller #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned POS_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             rec_x,
  output logic             rec_clear,
  input  logic             rec_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_hit,
  output logic [POS_W-1:0] out_first
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(WIDTH - 1);

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [POS_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             hit, hit_nxt;
  logic [POS_W-1:0] first, first_nxt;
  logic             in_ready_q;

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    idx_nxt   = idx;
    count_nxt = count;
    hit_nxt   = hit;
    first_nxt = first;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          shift_nxt = in_data;
          idx_nxt   = '0;
          count_nxt = '0;
          hit_nxt   = 1'b0;
          first_nxt = '0;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // rec_z belongs to the bit currently on rec_x, i.e. index idx
        if (rec_z) begin
          if (count != CNT_MAX) count_nxt = count + CNT_W'(1);
          if (!hit) begin
            hit_nxt   = 1'b1;
            first_nxt = idx;
          end
        end
        shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};
        idx_nxt   = idx + POS_W'(1);
        if (idx == LAST_IDX) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered output decode
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      idx        <= '0;
      count      <= '0;
      hit        <= 1'b0;
      first      <= '0;
      rec_x      <= 1'b0;
      rec_clear  <= 1'b1;
      out_valid  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      idx        <= idx_nxt;
      count      <= count_nxt;
      hit        <= hit_nxt;
      first      <= first_nxt;
      rec_x      <= (state_nxt == S_SHIFT) & shift_nxt[WIDTH-1];
      rec_clear  <= (state_nxt != S_SHIFT);
      out_valid  <= (state_nxt == S_DONE);
      in_ready_q <= (state_nxt == S_IDLE);
    end
  end

  // Readiness is suppressed during reset even though IDLE is already held
  assign in_ready  = in_ready_q & ~reset;
  assign out_count = count;
  assign out_hit   = hit;
  assign out_first = first;

endmodule

// File: tb/tb_seq_scan_controller.sv
// Self-checking bench for seq_scan_controller: table vectors, directed corner
// sequences and randomized words against a word-level reference model.
module tb_seq_scan_controller;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 3;
  localparam int POS_W   = 3;
  localparam int CNT_MAX = 7;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             rec_x;
  logic             rec_clear;
  logic             rec_z;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_hit;
  logic [POS_W-1:0] out_first;

  seq_scan_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rec_x     (rec_x),
    .rec_clear (rec_clear),
    .rec_z     (rec_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_hit   (out_hit),
    .out_first (out_first)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: phase 0 idle, 1..WIDTH shifting bit (phase-1), WIDTH+1 result
  int               m_ph    = 0;
  logic [WIDTH-1:0] m_word  = '0;
  logic [WIDTH-1:0] m_z     = '0;
  bit               m_fresh = 1'b1;
  bit               mon_en  = 1'b0;
  logic [WIDTH-1:0] zpat    = '0;
  logic             zjunk   = 1'b0;

  assign rec_z = (m_ph >= 1 && m_ph <= WIDTH) ? zpat[m_ph-1] : zjunk;

  always @(posedge clock) begin
    if (reset) begin
      m_ph    <= 0;
      m_fresh <= 1'b1;
    end else if (m_ph == 0) begin
      if (in_valid) begin
        m_ph    <= 1;
        m_word  <= in_data;
        m_z     <= '0;
        m_fresh <= 1'b0;
      end
    end else if (m_ph <= WIDTH) begin
      m_z[m_ph-1] <= rec_z;
      m_ph        <= m_ph + 1;
    end else if (out_ready) begin
      m_ph <= 0;
    end
  end

  function automatic int exp_count(input logic [WIDTH-1:0] z);
    int c = 0;
    for (int i = 0; i < WIDTH; i++) if (z[i]) c++;
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  function automatic int exp_first(input logic [WIDTH-1:0] z);
    for (int i = 0; i < WIDTH; i++) if (z[i]) return i;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    zjunk = 1'($urandom);
  endtask

  // Cycle-by-cycle comparison of every output against the model
  task automatic monitor();
    bit shifting;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        shifting = (m_ph >= 1 && m_ph <= WIDTH);
        check("mon_rec_clear", 32'(rec_clear), 32'(!shifting));
        check("mon_rec_x", 32'(rec_x), shifting ? 32'(m_word[WIDTH-m_ph]) : 32'd0);
        check("mon_out_valid", 32'(out_valid), 32'(m_ph == WIDTH + 1));
        check("mon_in_ready", 32'(in_ready), 32'(m_ph == 0 && !reset));
        if (m_ph == WIDTH + 1) begin
          check("mon_count", 32'(out_count), 32'(exp_count(m_z)));
          check("mon_hit", 32'(out_hit), 32'(m_z != '0));
          check("mon_first", 32'(out_first), 32'(exp_first(m_z)));
        end
        if (m_fresh && m_ph == 0) begin
          check("mon_fresh_count", 32'(out_count), 32'd0);
          check("mon_fresh_hit", 32'(out_hit), 32'd0);
          check("mon_fresh_first", 32'(out_first), 32'd0);
        end
      end
    end
  endtask

  task automatic scan(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] z, input int hold,
                      input int ec, input int eh, input int ef, input string tag);
    int n;
    logic [CNT_W-1:0] c0;
    logic [POS_W-1:0] f0;
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    check({tag, "_start_ready"}, 32'(in_ready), 32'd1);
    in_data   = w;
    zpat      = z;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check({tag, "_latency"}, 32'(n), 32'(WIDTH));
    c0 = out_count;
    f0 = out_first;
    for (int h = 0; h < hold; h++) begin
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_count"}, 32'(out_count), 32'(c0));
      check({tag, "_hold_first"}, 32'(out_first), 32'(f0));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_clear"}, 32'(rec_clear), 32'd1);
      tick();
    end
    check({tag, "_count"}, 32'(out_count), 32'(ec));
    check({tag, "_hit"}, 32'(out_hit), 32'(eh));
    check({tag, "_first"}, 32'(out_first), 32'(ef));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] z;
    int               hold;
    int               cnt;
    int               hit;
    int               first;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] rw, rz;
    tbl[0] = '{8'b1010_0110, 8'b0000_0000, 0, 0, 0, 0};
    tbl[1] = '{8'b1010_0110, 8'b0010_0100, 0, 2, 1, 2};
    tbl[2] = '{8'b0011_1100, 8'b1111_1111, 0, 7, 1, 0};
    tbl[3] = '{8'b1111_0000, 8'b1000_0000, 1, 1, 1, 7};
    tbl[4] = '{8'b0101_0101, 8'b0101_0000, 5, 2, 1, 4};
    tbl[5] = '{8'b1100_1010, 8'b1111_1110, 0, 7, 1, 1};
    tbl[6] = '{8'b0110_1001, 8'b0111_1110, 2, 6, 1, 1};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    fork monitor(); join_none
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_rec_clear", 32'(rec_clear), 32'd1);
    check("rst_rec_x", 32'(rec_x), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_hit", 32'(out_hit), 32'd0);
    check("post_rst_first", 32'(out_first), 32'd0);
    mon_en = 1'b1;

    // Table vectors, issued back to back
    for (int i = 0; i < 7; i++)
      scan(tbl[i].word, tbl[i].z, tbl[i].hold, tbl[i].cnt, tbl[i].hit, tbl[i].first, "tbl");

    // Reset while bit index 4 is on rec_x discards the partial scan
    in_data = 8'hFF; zpat = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("midrst_rec_x", 32'(rec_x), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_count", 32'(out_count), 32'd0);
    check("midrst_hit", 32'(out_hit), 32'd0);
    check("midrst_clear", 32'(rec_clear), 32'd1);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("midrst_release_ready", 32'(in_ready), 32'd1);
    scan(8'h5A, 8'h08, 0, 1, 1, 3, "after_rst");

    // in_valid asserted throughout SHIFT and DONE must not start another scan
    in_data = 8'hC3; zpat = 8'h11; in_valid = 1'b1;
    tick();
    in_data = 8'h3C;
    for (int i = 0; i < WIDTH; i++) begin
      in_valid = 1'($urandom) | (i == 0);
      tick();
    end
    in_valid = 1'b1;
    repeat (2) tick();
    check("ivpulse_valid", 32'(out_valid), 32'd1);
    check("ivpulse_count", 32'(out_count), 32'd2);
    check("ivpulse_first", 32'(out_first), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (3) begin
      check("ivpulse_stay_idle", 32'(in_ready), 32'd1);
      tick();
    end

    // Randomized words with random stalls and idle gaps
    for (int k = 0; k < 150; k++) begin
      rw = WIDTH'($urandom);
      rz = WIDTH'($urandom) & WIDTH'($urandom);
      if (k % 10 == 0) rz = '1;
      repeat ($urandom_range(0, 2)) tick();
      scan(rw, rz, int'($urandom_range(0, 3)), exp_count(rz), int'(rz != '0), exp_first(rz), "rand");
    end

    repeat (2) tick();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
